// File: rtl/neighbourhood_stream.sv
// Frame-buffered Game of Life neighbourhood producer: loads one generation as a raster
// stream, then emits the eight neighbours plus centre of every cell in raster order.
module neighbourhood_stream #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16,
   parameter int WRAP   = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic in_ready,
   input  logic in_cell,
   output logic out_valid,
   input  logic out_ready,
   output logic n,
   output logic ne,
   output logic e,
   output logic se,
   output logic s,
   output logic sw,
   output logic w,
   output logic nw,
   output logic center,
   output logic out_last
);

   localparam int N  = WIDTH * HEIGHT;
   localparam int AW = $clog2(N);
   localparam int RW = $clog2(HEIGHT);
   localparam int CW = $clog2(WIDTH);

   localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
   localparam logic [RW-1:0] ROW_MAX  = RW'(HEIGHT - 1);
   localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH - 1);

   typedef enum logic {LOAD = 1'b0, SCAN = 1'b1} state_t;

   state_t          state_q;
   logic [AW-1:0]   idx_q;
   logic [RW-1:0]   row_q;
   logic [CW-1:0]   col_q;
   logic [N-1:0]    store_q;

   logic            load_hs;
   logic            scan_hs;
   logic [RW-1:0]   row_up;
   logic [RW-1:0]   row_dn;
   logic [CW-1:0]   col_lt;
   logic [CW-1:0]   col_rt;
   logic            up_ok;
   logic            dn_ok;
   logic            lt_ok;
   logic            rt_ok;

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == SCAN);
   assign load_hs   = in_valid && in_ready;
   assign scan_hs   = out_valid && out_ready;

   // Every location is rewritten during LOAD before SCAN reads it, so no reset is needed.
   always_ff @(posedge clk) begin
      if (load_hs) begin
         store_q[idx_q] <= in_cell;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         idx_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (load_hs) begin
                  if (idx_q == IDX_LAST) begin
                     idx_q   <= '0;
                     state_q <= SCAN;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            SCAN: begin
               if (scan_hs) begin
                  if (col_q == COL_MAX) begin
                     col_q <= '0;
                     if (row_q == ROW_MAX) begin
                        row_q   <= '0;
                        state_q <= LOAD;
                     end else begin
                        row_q <= row_q + 1'b1;
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   function automatic logic cell_at(input logic [RW-1:0] row, input logic [CW-1:0] col);
      return store_q[AW'(row) * AW'(WIDTH) + AW'(col)];
   endfunction

   // Off-grid neighbours either read as dead or fold to the opposite edge.
   always_comb begin
      row_up = (row_q == '0)     ? ROW_MAX : row_q - 1'b1;
      row_dn = (row_q == ROW_MAX) ? '0     : row_q + 1'b1;
      col_lt = (col_q == '0)     ? COL_MAX : col_q - 1'b1;
      col_rt = (col_q == COL_MAX) ? '0     : col_q + 1'b1;
      up_ok  = (row_q != '0)      || (WRAP != 0);
      dn_ok  = (row_q != ROW_MAX) || (WRAP != 0);
      lt_ok  = (col_q != '0)      || (WRAP != 0);
      rt_ok  = (col_q != COL_MAX) || (WRAP != 0);

      n        = out_valid && up_ok          && cell_at(row_up, col_q);
      ne       = out_valid && up_ok && rt_ok && cell_at(row_up, col_rt);
      e        = out_valid && rt_ok          && cell_at(row_q,  col_rt);
      se       = out_valid && dn_ok && rt_ok && cell_at(row_dn, col_rt);
      s        = out_valid && dn_ok          && cell_at(row_dn, col_q);
      sw       = out_valid && dn_ok && lt_ok && cell_at(row_dn, col_lt);
      w        = out_valid && lt_ok          && cell_at(row_q,  col_lt);
      nw       = out_valid && up_ok && lt_ok && cell_at(row_up, col_lt);
      center   = out_valid && cell_at(row_q, col_q);
      out_last = out_valid && (row_q == ROW_MAX) && (col_q == COL_MAX);
   end

endmodule

// File: tb/tb_neighbourhood_stream.sv
// Directed bench for neighbourhood_stream: two 4x4 instances (dead edge and toroidal)
// share the same stimulus; each scenario task checks its own results.
module tb_neighbourhood_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_cell = 1'b0;
   logic out_ready = 1'b0;

   logic in_ready0, out_valid0, last0;
   logic in_ready1, out_valid1, last1;
   logic n0, ne0, e0, se0, s0, sw0, w0, nw0, c0;
   logic n1, ne1, e1, se1, s1, sw1, w1, nw1, c1;
   logic [8:0] v0, v1;

   int total = 0;
   int bad = 0;

   // Captured outputs per cell of the most recent completed scan.
   logic [8:0] got0 [16];
   logic [8:0] got1 [16];
   logic       gotl [16];

   always #5 clk = ~clk;

   assign v0 = {n0, ne0, e0, se0, s0, sw0, w0, nw0, c0};
   assign v1 = {n1, ne1, e1, se1, s1, sw1, w1, nw1, c1};

   neighbourhood_stream #(.WIDTH(4), .HEIGHT(4), .WRAP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_cell(in_cell),
      .out_valid(out_valid0), .out_ready(out_ready),
      .n(n0), .ne(ne0), .e(e0), .se(se0), .s(s0), .sw(sw0), .w(w0), .nw(nw0),
      .center(c0), .out_last(last0)
   );

   neighbourhood_stream #(.WIDTH(4), .HEIGHT(4), .WRAP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_cell(in_cell),
      .out_valid(out_valid1), .out_ready(out_ready),
      .n(n1), .ne(ne1), .e(e1), .se(se1), .s(s1), .sw(sw1), .w(w1), .nw(nw1),
      .center(c1), .out_last(last1)
   );

   // Reference neighbourhood using signed offsets and modulo folding.
   function automatic logic [8:0] ref_nb(input logic [15:0] f, input int r, input int c, input bit wrap);
      int dr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
      int dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
      logic [8:0] res;
      res = '0;
      for (int k = 0; k < 8; k++) begin
         int rr, cc;
         rr = r + dr[k];
         cc = c + dc[k];
         if (rr < 0 || rr > 3 || cc < 0 || cc > 3) begin
            if (wrap) begin
               rr = (rr + 4) % 4;
               cc = (cc + 4) % 4;
               res[8-k] = f[rr*4+cc];
            end
         end else begin
            res[8-k] = f[rr*4+cc];
         end
      end
      res[0] = f[r*4+c];
      return res;
   endfunction

   task automatic load_frame(input logic [15:0] frame, input bit gaps);
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_cell  = frame[i];
         total++;
         if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1 || out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL load_ready cell=%0d got rdy=%b/%b vld=%b/%b want rdy=1 vld=0",
                     i, in_ready0, in_ready1, out_valid0, out_valid1);
         end
         @(posedge clk);
         @(negedge clk);
         if (gaps && i != 15) begin
            in_valid = 1'b0;
            in_cell  = ~frame[i];
            @(posedge clk);
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      in_cell  = 1'b0;
      total++;
      if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1 || in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
         bad++;
         $display("FAIL load_latency got vld=%b/%b rdy=%b/%b want vld=1 rdy=0",
                  out_valid0, out_valid1, in_ready0, in_ready1);
      end
      $display("load frame=%h gaps=%0d", frame, gaps);
   endtask

   // Scans with optional 5-cycle stall or reset at a given output index; returns handshake count.
   task automatic scan_frame(input logic [15:0] frame, input int stall_at, input int reset_at,
                             input bit junk_in, output int hs);
      int cyc;
      bit stalled;
      logic [8:0] h0, h1;
      hs = 0;
      cyc = 0;
      stalled = 1'b0;
      in_valid = junk_in;
      in_cell  = junk_in;
      while (hs < 16 && cyc < 200) begin
         cyc++;
         total++;
         if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1 || in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
            bad++;
            $display("FAIL scan_flags idx=%0d got vld=%b/%b rdy=%b/%b want vld=1 rdy=0",
                     hs, out_valid0, out_valid1, in_ready0, in_ready1);
         end
         if (reset_at == hs) begin
            #2 rst_n = 1'b0;
            #1;
            total++;
            if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || in_ready0 !== 1'b1 || in_ready1 !== 1'b1 ||
                v0 !== 9'h0 || v1 !== 9'h0 || last0 !== 1'b0 || last1 !== 1'b0) begin
               bad++;
               $display("FAIL reset_async got vld=%b/%b rdy=%b/%b nb=%h/%h want vld=0 rdy=1 nb=0",
                        out_valid0, out_valid1, in_ready0, in_ready1, v0, v1);
            end
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            in_valid = 1'b0;
            $display("reset asserted at output %0d", hs);
            return;
         end
         total++;
         if (v0 !== ref_nb(frame, hs / 4, hs % 4, 1'b0) || v1 !== ref_nb(frame, hs / 4, hs % 4, 1'b1) ||
             last0 !== (hs == 15) || last1 !== (hs == 15)) begin
            bad++;
            $display("FAIL scan_cell r=%0d c=%0d got nb=%h/%h last=%b/%b want nb=%h/%h last=%b",
                     hs / 4, hs % 4, v0, v1, last0, last1,
                     ref_nb(frame, hs / 4, hs % 4, 1'b0), ref_nb(frame, hs / 4, hs % 4, 1'b1), hs == 15);
         end
         got0[hs] = v0;
         got1[hs] = v1;
         gotl[hs] = last0;
         if (stall_at == hs && !stalled) begin
            stalled = 1'b1;
            h0 = v0;
            h1 = v1;
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(posedge clk);
               @(negedge clk);
               total++;
               if (v0 !== h0 || v1 !== h1 || out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin
                  bad++;
                  $display("FAIL stall_hold cyc=%0d got nb=%h/%h vld=%b/%b want nb=%h/%h vld=1",
                           k, v0, v1, out_valid0, out_valid1, h0, h1);
               end
            end
            $display("stall 5 cycles at output %0d", hs);
            continue;
         end
         out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         $display("out r=%0d c=%0d nb0=%h nb1=%h last=%b", hs / 4, hs % 4, got0[hs], got1[hs], gotl[hs]);
         hs++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_cell   = 1'b0;
      total++;
      if (hs != 16 || in_ready0 !== 1'b1 || in_ready1 !== 1'b1 || out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
         bad++;
         $display("FAIL scan_end got hs=%0d rdy=%b/%b vld=%b/%b want hs=16 rdy=1 vld=0",
                  hs, in_ready0, in_ready1, out_valid0, out_valid1);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || v0 !== 9'h0 || last0 !== 1'b0 ||
          in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || v1 !== 9'h0 || last1 !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got rdy=%b vld=%b nb=%h last=%b want rdy=1 vld=0 nb=0 last=0",
                  in_ready0, out_valid0, v0, last0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset state checked");
   endtask

   task automatic test_single_centre;
      int hs;
      load_frame(16'h0020, 1'b0);
      scan_frame(16'h0020, -1, -1, 1'b0, hs);
      total++;
      if (got0[0] !== 9'h020 || got0[5] !== 9'h001 || got0[10] !== 9'h002 || got0[15] !== 9'h000 ||
          gotl[15] !== 1'b1 || gotl[14] !== 1'b0) begin
         bad++;
         $display("FAIL single_centre got %h %h %h %h last=%b want 020 001 002 000 last=1",
                  got0[0], got0[5], got0[10], got0[15], gotl[15]);
      end
   endtask

   task automatic test_all_ones;
      int hs;
      load_frame(16'hFFFF, 1'b0);
      scan_frame(16'hFFFF, -1, -1, 1'b0, hs);
      total++;
      if (got0[0] !== 9'h071 || got0[6] !== 9'h1FF || got0[15] !== 9'h107) begin
         bad++;
         $display("FAIL all_ones_dead got %h %h %h want 071 1ff 107", got0[0], got0[6], got0[15]);
      end
      for (int i = 0; i < 16; i++) begin
         total++;
         if (got1[i] !== 9'h1FF) begin
            bad++;
            $display("FAIL all_ones_wrap cell=%0d got %h want 1ff", i, got1[i]);
         end
      end
   endtask

   task automatic test_wrap_corner;
      int hs;
      load_frame(16'h0001, 1'b0);
      scan_frame(16'h0001, -1, -1, 1'b0, hs);
      total++;
      if (got1[15] !== 9'h020 || got1[3] !== 9'h040 || got1[12] !== 9'h010 || got1[5] !== 9'h002) begin
         bad++;
         $display("FAIL wrap_corner got %h %h %h %h want 020 040 010 002",
                  got1[15], got1[3], got1[12], got1[5]);
      end
      total++;
      if (got0[15] !== 9'h000 || got0[3] !== 9'h000 || got0[5] !== 9'h002) begin
         bad++;
         $display("FAIL dead_corner got %h %h %h want 000 000 002", got0[15], got0[3], got0[5]);
      end
   endtask

   task automatic test_gapped_load;
      int hs;
      out_ready = 1'b1;  // no effect while out_valid is low
      load_frame(16'hA5C3, 1'b1);
      out_ready = 1'b0;
      scan_frame(16'hA5C3, -1, -1, 1'b0, hs);
   endtask

   task automatic test_backpressure;
      int hs;
      load_frame(16'h3C96, 1'b0);
      scan_frame(16'h3C96, 2, -1, 1'b1, hs);
      total++;
      if (hs != 16) begin
         bad++;
         $display("FAIL backpressure_count got %0d want 16", hs);
      end
   endtask

   task automatic test_reset_midscan;
      int hs;
      load_frame(16'h1248, 1'b0);
      scan_frame(16'h1248, -1, 6, 1'b0, hs);
      total++;
      if (hs != 6) begin
         bad++;
         $display("FAIL reset_midscan_index got %0d want 6", hs);
      end
      load_frame(16'h8421, 1'b0);
      scan_frame(16'h8421, -1, -1, 1'b0, hs);
      total++;
      if (got0[0] !== 9'h021 || got1[0] !== 9'h023) begin
         bad++;
         $display("FAIL reload_first got %h/%h want 021/023", got0[0], got1[0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_centre();
      test_all_ones();
      test_wrap_corner();
      test_gapped_load();
      test_backpressure();
      test_reset_midscan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
